// File: rtl/fpaddsub_norm_shift_stage.sv
// Post-add normalisation stage: left-shifts the raw magnitude sum by its leading-nought
// count, adjusts the biased exponent and flags zero / underflow / overflow. Two register stages.
module fpaddsub_norm_shift_stage #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_sum,
    input  logic [5:0]       in_lnc,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_uf,
    output logic             out_of
);

    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    // Handshake: a beat moves across a side when valid && ready on that side. A source holds
    // valid and payload stable until accepted; ready never looks at the same side's valid.
    logic             s1_valid;
    logic [31:0]      s1_sum;
    logic [5:0]       s1_lnc;
    logic [EXP_W-1:0] s1_exp;
    logic             s1_sign;
    logic             s2_valid;
    logic             s2_adv;

    assign s2_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    logic [EW-1:0]    e_adj;
    logic             e_le0;
    logic             e_ovf;
    logic             lnc_zero;
    logic [31:0]      n_mant;
    logic [EXP_W-1:0] n_exp;
    logic             n_sign;
    logic             n_zero;
    logic             n_uf;
    logic             n_of;

    // Exponent is signed EW bits; counts above 32 are illegal and behave as an all-zero sum.
    assign e_adj    = {2'b00, s1_exp} + EW'(1) - EW'(s1_lnc);
    assign e_le0    = e_adj[EW-1] || (e_adj == '0);
    assign e_ovf    = !e_adj[EW-1] && (e_adj >= EXP_MAX);
    assign lnc_zero = (s1_lnc >= 6'd32);

    always_comb begin
        n_mant = '0;
        n_exp  = '0;
        n_sign = s1_sign;
        n_zero = 1'b0;
        n_uf   = 1'b0;
        n_of   = 1'b0;
        if (lnc_zero) begin
            n_zero = 1'b1;
            n_sign = 1'b0;
        end else if (e_le0) begin
            n_uf = 1'b1;
        end else if (e_ovf) begin
            n_of  = 1'b1;
            n_exp = '1;
        end else begin
            n_mant = s1_sum << s1_lnc[4:0];
            n_exp  = e_adj[EXP_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_lnc   <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_sum   <= in_sum;
            s1_lnc   <= in_lnc;
            s1_exp   <= in_exp;
            s1_sign  <= in_sign;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output registers keep their last value when drained so a stalled beat never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_mant <= '0;
            out_exp  <= '0;
            out_sign <= 1'b0;
            out_zero <= 1'b0;
            out_uf   <= 1'b0;
            out_of   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= 1'b1;
            out_mant <= n_mant;
            out_exp  <= n_exp;
            out_sign <= n_sign;
            out_zero <= n_zero;
            out_uf   <= n_uf;
            out_of   <= n_of;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpaddsub_norm_shift_stage.sv
// Bench for the normalisation stage: directed literal cases, backpressure, throughput,
// reset flush and a randomized stream checked against an arithmetic reference model.
module tb_fpaddsub_norm_shift_stage;

    localparam int W = 44;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sum = '0;
    logic [5:0]  in_lnc = '0;
    logic [7:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_zero;
    logic        out_uf;
    logic        out_of;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic rand_rdy = 1'b0;
    logic saw_in_stall = 1'b0;
    logic [W-1:0] exp_q[$];

    fpaddsub_norm_shift_stage #(.EXP_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_lnc(in_lnc), .in_exp(in_exp), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
        .out_zero(out_zero), .out_uf(out_uf), .out_of(out_of)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Result packed as {mant, exp, sign, zero, uf, of}
    function automatic logic [W-1:0] model(logic [31:0] s, logic [5:0] l, logic [7:0] e, logic sg);
        int ee;
        logic [31:0] m;
        ee = int'(e) + 1 - int'(l);
        if (l >= 6'd32) return {32'h0, 8'h00, 1'b0, 3'b100};
        if (ee <= 0)    return {32'h0, 8'h00, sg, 3'b010};
        if (ee >= 255)  return {32'h0, 8'hff, sg, 3'b001};
        m = s << l;
        return {m, 8'(ee), sg, 3'b000};
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {out_mant, out_exp, out_sign, out_zero, out_uf, out_of};
    endfunction

    function automatic logic [5:0] count_lnc(logic [31:0] s);
        for (int i = 31; i >= 0; i--) if (s[i]) return 6'(31 - i);
        return 6'd32;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_out = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_vs_occupancy", W'(in_ready),
                  W'(!(exp_q.size() == 2 && !out_ready)));
            if (exp_q.size() == 0) check("out_valid_when_empty", W'(out_valid), W'(0));
            if (!in_ready) saw_in_stall = 1'b1;
            if (prev_stall) begin
                check("stall_valid_held", W'(out_valid), W'(1));
                check("stall_data_held", dut_out(), prev_out);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", W'(1), W'(0));
                end else begin
                    check("beat_vs_model", dut_out(), exp_q.pop_front());
                end
                out_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sum, in_lnc, in_exp, in_sign));
            prev_stall = out_valid && !out_ready;
            prev_out   = dut_out();
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send(logic [31:0] s, logic [5:0] l, logic [7:0] e, logic sg);
        int n = 0;
        in_valid = 1'b1; in_sum = s; in_lnc = l; in_exp = e; in_sign = sg;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck 0, expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic directed(string name, logic [31:0] s, logic [5:0] l, logic [7:0] e, logic sg,
                            logic [W-1:0] req);
        int n = 0;
        send(s, l, e, sg);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check({name, "_latency"}, W'(n), W'(2));
        check(name, dut_out(), req);
        idle(1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", W'(exp_q.size()), W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fork
            forever begin
                @(posedge clk); #1;
                if (rand_rdy) out_ready = ($urandom_range(0, 99) < 70);
            end
        join_none

        idle(3);
        @(negedge clk);
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_outputs", dut_out(), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Model pins against hand-computed values
        check("model_carry", model(32'h8000_0000, 6'd0, 8'd127, 1'b0), {32'h8000_0000, 8'd128, 4'b0000});
        check("model_of", model(32'h8000_0000, 6'd0, 8'd254, 1'b1), {32'h0, 8'hff, 4'b1001});

        directed("carry", 32'h8000_0000, 6'd0, 8'd127, 1'b0, {32'h8000_0000, 8'd128, 4'b0000});
        directed("normal1", 32'h4000_0000, 6'd1, 8'd127, 1'b1, {32'h8000_0000, 8'd127, 4'b1000});
        directed("normal20", 32'h0000_0C00, 6'd20, 8'd100, 1'b0, {32'hC000_0000, 8'd81, 4'b0000});
        directed("zero", 32'h0, 6'd32, 8'd77, 1'b1, {32'h0, 8'h00, 4'b0100});
        directed("underflow", 32'h0000_0001, 6'd31, 8'd20, 1'b1, {32'h0, 8'h00, 4'b1010});
        directed("overflow", 32'h8000_0000, 6'd0, 8'd254, 1'b0, {32'h0, 8'hff, 4'b0001});
        directed("exp_one", 32'h4000_0000, 6'd1, 8'd1, 1'b0, {32'h8000_0000, 8'd1, 4'b0000});
        directed("exp_zero_uf", 32'h4000_0000, 6'd1, 8'd0, 1'b0, {32'h0, 8'h00, 4'b0010});
        directed("exp_253_max", 32'h8000_0000, 6'd0, 8'd253, 1'b1, {32'h8000_0000, 8'd254, 4'b1000});
        directed("illegal_lnc", 32'h1234_5678, 6'd40, 8'd90, 1'b1, {32'h0, 8'h00, 4'b0100});

        // Backpressure: 5 beats, out_ready low for cycles 3..6
        begin
            int base;
            saw_in_stall = 1'b0;
            base = out_cnt;
            fork
                for (int i = 0; i < 5; i++)
                    send(32'h0100_0000 << i, 6'd7 - 6'(i), 8'd60 + 8'(i), i[0]);
                begin
                    idle(3);
                    out_ready = 1'b0;
                    idle(4);
                    out_ready = 1'b1;
                end
            join
            drain();
            idle(2);
            check("bp_in_ready_dropped", W'(saw_in_stall), W'(1));
            check("bp_beat_count", W'(out_cnt - base), W'(5));
        end

        // Throughput: 16 back-to-back beats
        begin
            int ones = 0;
            out_ready = 1'b1;
            fork
                begin
                    in_valid = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        in_sum = 32'h0000_8000 << i[3:0];
                        in_lnc = 6'd16 - 6'(i);
                        in_exp = 8'd30 + 8'(i);
                        in_sign = i[1];
                        @(posedge clk); #1;
                    end
                    in_valid = 1'b0;
                end
                begin
                    repeat (2) begin
                        @(negedge clk);
                        check("tp_pre_valid", W'(out_valid), W'(0));
                    end
                    repeat (16) begin
                        @(negedge clk);
                        if (out_valid) ones++;
                    end
                    check("tp_consecutive", W'(ones), W'(16));
                    @(negedge clk);
                    check("tp_post_valid", W'(out_valid), W'(0));
                end
            join
            idle(2);
        end

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(32'h4000_0000, 6'd1, 8'd10, 1'b1);
        send(32'h2000_0000, 6'd2, 8'd10, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_outputs", dut_out(), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        idle(1);
        directed("post_reset", 32'h0000_0003, 6'd30, 8'd140, 1'b0, {32'hC000_0000, 8'd111, 4'b0000});

        // Randomized stream with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] s;
            logic [5:0]  l;
            s = $urandom >> $urandom_range(0, 32);
            l = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(33, 63)) : count_lnc(s);
            send(s, l, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        idle(1);
        out_ready = 1'b1;
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
